// File: rtl/bsg_dff_skid_slice_if.sv
// Handshake bundle for bsg_dff_skid_slice: upstream valid/ready/data, downstream
// valid/ready/data, and the occupancy debug output. The slave modport is the slice side.
interface bsg_dff_skid_slice_if #(
   parameter int unsigned width_p = 16
) ();

   logic               v_i;
   logic [width_p-1:0] data_i;
   logic               ready_o;
   logic               v_o;
   logic [width_p-1:0] data_o;
   logic               ready_i;
   logic [1:0]         count_o;

   modport slave (
      input  v_i,
      input  data_i,
      input  ready_i,
      output ready_o,
      output v_o,
      output data_o,
      output count_o
   );

   modport master (
      output v_i,
      output data_i,
      output ready_i,
      input  ready_o,
      input  v_o,
      input  data_o,
      input  count_o
   );

endinterface

// File: rtl/bsg_dff_skid_slice.sv
// Two-entry valid/ready register slice. The head register drives data_o directly and the
// tail register absorbs one beat of backpressure, so ready_o, v_o and data_o are all
// registered and no combinational path crosses the slice in either direction.
module bsg_dff_skid_slice #(
   parameter int unsigned width_p = 16
) (
   input logic                 clk_i,
   input logic                 reset_n_i,
   bsg_dff_skid_slice_if.slave bus
);

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StFull  = 2'd2
   } state_e;

   state_e             r_state;
   state_e             w_state_d;
   logic               r_init;
   logic [width_p-1:0] r_head;
   logic [width_p-1:0] r_tail;
   logic [width_p-1:0] w_head_d;
   logic               w_head_we;
   logic               w_tail_we;
   logic               w_enq;
   logic               w_deq;

   // ready_o only depends on flops; r_init holds it low for the first cycle out of reset
   assign bus.ready_o = r_init & (r_state != StFull);
   assign bus.v_o     = (r_state != StEmpty);
   assign bus.data_o  = r_head;
   assign bus.count_o = (r_state == StFull) ? 2'd2 : ((r_state == StOne) ? 2'd1 : 2'd0);

   // v_i is masked by ready_o, so an unknown v_i while not ready cannot leak into state
   assign w_enq = bus.v_i & bus.ready_o;
   assign w_deq = bus.v_o & bus.ready_i;

   // Next-state and register-load decode
   always_comb begin
      w_state_d = r_state;
      w_head_we = 1'b0;
      w_tail_we = 1'b0;
      w_head_d  = bus.data_i;
      unique case (r_state)
         StEmpty: begin
            if (w_enq) begin
               w_state_d = StOne;
               w_head_we = 1'b1;
            end
         end
         StOne: begin
            if (w_enq && w_deq) begin
               w_head_we = 1'b1;
            end else if (w_enq) begin
               w_state_d = StFull;
               w_tail_we = 1'b1;
            end else if (w_deq) begin
               w_state_d = StEmpty;
            end
         end
         StFull: begin
            // Skid beat moves up to the head; upstream is blocked so nothing new enters
            if (w_deq) begin
               w_state_d = StOne;
               w_head_we = 1'b1;
               w_head_d  = r_tail;
            end
         end
         default: begin
            w_state_d = StEmpty;
         end
      endcase
   end

   // Control state: cleared asynchronously so v_o and ready_o drop without a clock
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= StEmpty;
         r_init  <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_init  <= 1'b1;
      end
   end

   // Payload registers: no reset, contents are only meaningful while v_o is high
   always_ff @(posedge clk_i) begin
      if (w_head_we) begin
         r_head <= w_head_d;
      end
      if (w_tail_we) begin
         r_tail <= bus.data_i;
      end
   end

endmodule

// File: tb/tb_bsg_dff_skid_slice.sv
// Directed and randomised checks for bsg_dff_skid_slice against a bench-side queue model.
module tb_bsg_dff_skid_slice;

   localparam int unsigned Width = 16;

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_errors;

   bsg_dff_skid_slice_if #(.width_p(Width)) bus ();

   bsg_dff_skid_slice #(.width_p(Width)) dut (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after each rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag, input logic exp_ready);
      check({tag, " v_o"},     32'(bus.v_o),     32'(1'b0));
      check({tag, " count_o"}, 32'(bus.count_o), 32'(2'd0));
      check({tag, " ready_o"}, 32'(bus.ready_o), 32'(exp_ready));
   endtask

   logic [Width-1:0] m_q[$];
   logic             m_v;
   logic             m_r;
   logic [Width-1:0] m_d;
   logic             m_enq;
   logic             m_deq;

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      reset_n     = 1'b1;
      bus.v_i     = 1'b0;
      bus.data_i  = '0;
      bus.ready_i = 1'b0;

      // 1. Reset and release
      #1 reset_n = 1'b0;
      #1 check_idle("reset", 1'b0);
      step();
      check_idle("in reset", 1'b0);
      reset_n = 1'b0;
      #1 reset_n = 1'b1;
      #1 check_idle("first cycle", 1'b0);
      step();
      check_idle("second cycle", 1'b1);

      // 2. Streaming at one beat per cycle
      bus.ready_i = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         bus.v_i    = 1'b1;
         bus.data_i = 16'(k);
         step();
         check($sformatf("stream v_o %0d", k),     32'(bus.v_o),     32'(1'b1));
         check($sformatf("stream data_o %0d", k),  32'(bus.data_o),  32'(k));
         check($sformatf("stream count_o %0d", k), 32'(bus.count_o), 32'(2'd1));
         check($sformatf("stream ready_o %0d", k), 32'(bus.ready_o), 32'(1'b1));
      end
      bus.v_i = 1'b0;
      step();
      check_idle("stream drained", 1'b1);

      // 3. Fill under backpressure; third beat must be refused
      bus.ready_i = 1'b0;
      bus.v_i     = 1'b1;
      bus.data_i  = 16'hAAAA;
      step();
      check("fill1 count_o", 32'(bus.count_o), 32'(2'd1));
      check("fill1 data_o",  32'(bus.data_o),  32'(16'hAAAA));
      bus.data_i = 16'h5555;
      step();
      check("full count_o", 32'(bus.count_o), 32'(2'd2));
      check("full ready_o", 32'(bus.ready_o), 32'(1'b0));
      check("full data_o",  32'(bus.data_o),  32'(16'hAAAA));
      bus.data_i = 16'hFFFF;
      step();
      check("blocked count_o", 32'(bus.count_o), 32'(2'd2));
      check("blocked data_o",  32'(bus.data_o),  32'(16'hAAAA));
      check("blocked v_o",     32'(bus.v_o),     32'(1'b1));
      bus.v_i    = 1'bx;
      bus.data_i = 16'hxxxx;
      step();
      check("x v_i count_o", 32'(bus.count_o), 32'(2'd2));
      check("x v_i data_o",  32'(bus.data_o),  32'(16'hAAAA));

      // 4. Drain the two held beats in order
      bus.v_i     = 1'b0;
      bus.data_i  = 16'hFFFF;
      bus.ready_i = 1'b1;
      step();
      check("drain1 data_o",  32'(bus.data_o),  32'(16'h5555));
      check("drain1 count_o", 32'(bus.count_o), 32'(2'd1));
      check("drain1 ready_o", 32'(bus.ready_o), 32'(1'b1));
      step();
      check_idle("drain2", 1'b1);

      // 5. Random traffic against a queue model
      m_q.delete();
      for (int c = 0; c < 10000; c++) begin
         m_v         = 1'($urandom_range(0, 1));
         m_r         = 1'($urandom_range(0, 1));
         m_d         = 16'($urandom);
         bus.v_i     = m_v;
         bus.ready_i = m_r;
         bus.data_i  = m_d;
         #3;
         check("rand v_o",     32'(bus.v_o),     32'(m_q.size() != 0));
         check("rand ready_o", 32'(bus.ready_o), 32'(m_q.size() < 2));
         check("rand count_o", 32'(bus.count_o), 32'(m_q.size()));
         if (m_q.size() != 0) begin
            check("rand data_o", 32'(bus.data_o), 32'(m_q[0]));
         end
         m_enq = m_v & (m_q.size() < 2);
         m_deq = m_r & (m_q.size() != 0);
         if (m_deq) void'(m_q.pop_front());
         if (m_enq) m_q.push_back(m_d);
         step();
      end

      // 6. Asynchronous reset while full
      bus.ready_i = 1'b0;
      bus.v_i     = 1'b1;
      bus.data_i  = 16'h0101;
      step();
      bus.data_i = 16'h0202;
      step();
      step();
      check("pre-reset count_o", 32'(bus.count_o), 32'(2'd2));
      #2 reset_n = 1'b0;
      #1 check_idle("async reset", 1'b0);
      bus.v_i = 1'b0;
      step();
      reset_n = 1'b1;
      #1 check_idle("post-reset first cycle", 1'b0);
      step();
      check_idle("post-reset second cycle", 1'b1);
      bus.v_i     = 1'b1;
      bus.ready_i = 1'b1;
      bus.data_i  = 16'h1234;
      step();
      check("post-reset v_o",     32'(bus.v_o),     32'(1'b1));
      check("post-reset data_o",  32'(bus.data_o),  32'(16'h1234));
      check("post-reset count_o", 32'(bus.count_o), 32'(2'd1));
      bus.v_i = 1'b0;
      step();
      check_idle("post-reset drained", 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Occupancy must never exceed two entries
   always @(negedge clk) begin
      if (reset_n) begin
         n_checks++;
         assert (bus.count_o <= 2'd2)
         else begin
            n_errors++;
            $error("FAIL count bound: observed %0d expected <= 2", bus.count_o);
         end
      end
   end

endmodule
